// File: rtl/object_trajectory.sv
// Single flying object: launched by valid/ready, steps by signed velocity every tick_period clocks,
// retires on kill or leaving the playfield. Optional gravity on vy when OBJ_GRAVITY_EN is defined.
module object_trajectory #(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int VW       = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int DIVW     = 32,
  parameter int GRAVITY  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            launch_valid,
  output logic            launch_ready,
  input  logic [XW-1:0]   init_x,
  input  logic [YW-1:0]   init_y,
  input  logic [VW-1:0]   init_vx,
  input  logic [VW-1:0]   init_vy,
  input  logic [DIVW-1:0] tick_period,
  input  logic [XW-1:0]   obj_w,
  input  logic            kill,
  output logic [XW-1:0]   posx,
  output logic [YW-1:0]   posy,
  output logic            active,
  output logic            oob_pulse
);

  localparam int IXW = XW + 2;
  localparam int IYW = YW + 2;
  localparam int CW  = IXW + 2;

  localparam logic signed [CW-1:0]  X_SCREEN = CW'(SCREEN_W);
  localparam logic signed [IYW-1:0] Y_HI     = IYW'(SCREEN_H);
  localparam logic signed [IYW-1:0] Y_LO     = IYW'(-SCREEN_H);

  localparam logic signed [VW+1:0] V_MAX = (VW+2)'((2 ** (VW - 1)) - 1);
  localparam logic signed [VW+1:0] V_MIN = (VW+2)'(-(2 ** (VW - 1)));

`ifdef OBJ_GRAVITY_EN
  localparam logic signed [VW+1:0] G_STEP = (VW+2)'(GRAVITY);
`else
  // With gravity disabled the increment is zero, so vy stays constant for the flight.
  localparam logic signed [VW+1:0] G_STEP = (VW+2)'(GRAVITY * 0);
`endif

  typedef enum logic {IDLE, FLIGHT} state_t;

  state_t                 state;
  logic signed [IXW-1:0]  x;
  logic signed [IYW-1:0]  y;
  logic signed [VW-1:0]   vx;
  logic signed [VW-1:0]   vy;
  logic [DIVW-1:0]        period;
  logic [DIVW-1:0]        divider;

  logic                   step;
  logic signed [IXW-1:0]  x_step;
  logic signed [IYW-1:0]  y_step;
  logic signed [CW-1:0]   x_step_wide;
  logic signed [CW-1:0]   x_limit;
  logic                   oob;
  logic signed [VW+1:0]   vy_sum;
  logic signed [VW-1:0]   vy_grav;

  // period is stored already forced to >= 1, so period-1 never underflows
  assign step = (state == FLIGHT) && (divider == period - DIVW'(1));

  assign x_step      = x + {{(IXW-VW){vx[VW-1]}}, vx};
  assign y_step      = y + {{(IYW-VW){vy[VW-1]}}, vy};
  assign x_step_wide = {{(CW-IXW){x_step[IXW-1]}}, x_step};
  assign x_limit     = X_SCREEN - $signed({{(CW-XW){1'b0}}, obj_w});

  // Top exit is tolerated down to -SCREEN_H so arcs may leave and come back.
  assign oob = x_step[IXW-1] || (x_step_wide > x_limit) ||
               (y_step >= Y_HI) || (y_step < Y_LO);

  assign vy_sum = {{2{vy[VW-1]}}, vy} + G_STEP;

  always_comb begin
    vy_grav = vy_sum[VW-1:0];
    if (vy_sum > V_MAX) begin
      vy_grav = V_MAX[VW-1:0];
    end else if (vy_sum < V_MIN) begin
      vy_grav = V_MIN[VW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      vx           <= '0;
      vy           <= '0;
      period       <= DIVW'(1);
      divider      <= '0;
      posx         <= '0;
      posy         <= '0;
      active       <= 1'b0;
      oob_pulse    <= 1'b0;
      launch_ready <= 1'b1;
    end else begin
      oob_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_valid && launch_ready) begin
            state        <= FLIGHT;
            x            <= {2'b00, init_x};
            y            <= {2'b00, init_y};
            vx           <= init_vx;
            vy           <= init_vy;
            period       <= (tick_period == '0) ? DIVW'(1) : tick_period;
            divider      <= '0;
            posx         <= init_x;
            posy         <= init_y;
            active       <= 1'b1;
            launch_ready <= 1'b0;
          end
        end
        FLIGHT: begin
          if (kill) begin
            state        <= IDLE;
            active       <= 1'b0;
            launch_ready <= 1'b1;
          end else if (step) begin
            divider <= '0;
            if (oob) begin
              state        <= IDLE;
              active       <= 1'b0;
              launch_ready <= 1'b1;
              oob_pulse    <= 1'b1;
            end else begin
              x    <= x_step;
              y    <= y_step;
              vy   <= vy_grav;
              posx <= x_step[XW-1:0];
              posy <= y_step[IYW-1] ? '0 : y_step[YW-1:0];
            end
          end else begin
            divider <= divider + DIVW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
